// File: rtl/io_port_bank.sv
// Register-mapped bank of synchronised input / registered output channels with sticky change flags.
// Latency: reads return one cycle after rd_en; writes reach out_bus the cycle after wr_en.
// No backpressure: every strobed cycle is one transfer. Optional irq/MASK logic built with IO_PORT_IRQ_EN.
module io_port_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [3:0]                addr,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rdata,
    output logic                      rd_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    output logic [CHANNELS*WIDTH-1:0] out_bus,
    output logic                      irq
);

    localparam int         BW       = CHANNELS * WIDTH;
    localparam logic [3:0] A_FLAGS  = 4'h8;
    localparam logic [3:0] A_MASK   = 4'h9;
    localparam logic [3:0] A_STATUS = 4'hA;

    logic [BW-1:0]       sync1, sync2, hist, out_reg;
    logic [CHANNELS-1:0] flags, chg, flags_clr, flags_set, mask;
    logic [1:0]          warm;
    logic                armed;
    logic [WIDTH-1:0]    rd_mux, rdata_q;
    logic                rd_valid_q, irq_q;

    assign armed = (warm == 2'd2);

    always_comb begin
        chg = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            chg[k] = (sync2[k*WIDTH +: WIDTH] != hist[k*WIDTH +: WIDTH]);
        end
    end

    // Until armed, history tracks whatever stage-2 is about to load so inputs
    // that were already set at reset release never look like a change.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            warm  <= 2'd0;
        end else begin
            sync1 <= in_bus;
            sync2 <= sync1;
            hist  <= armed ? sync2 : sync1;
            if (!armed) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign flags_clr = (rd_en && addr == A_FLAGS) ? flags : '0;
    assign flags_set = armed ? chg : '0;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~flags_clr) | flags_set;
        end
    end

`ifdef IO_PORT_IRQ_EN
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr_en && addr == A_MASK) begin
                mask <= wdata[CHANNELS-1:0];
            end
            irq_q <= |(flags & mask);
        end
    end
`else
    assign mask  = '0;
    assign irq_q = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            out_reg <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (addr == 4'(k)) begin
                    out_reg[k*WIDTH +: WIDTH] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (addr == 4'(k)) begin
                rd_mux = sync2[k*WIDTH +: WIDTH];
            end
        end
        case (addr)
            A_FLAGS:  rd_mux[CHANNELS-1:0] = flags;
            A_MASK:   rd_mux[CHANNELS-1:0] = mask;
            A_STATUS: rd_mux[0]            = irq_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign out_bus  = out_reg;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed and randomised bench for io_port_bank against a cycle-level behavioural model.
// The model views inputs as a history of sampled values, not as synchroniser flops.
module tb_io_port_bank;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int BW = W * C;

    logic          clk_in;
    logic          reset;
    logic [3:0]    addr;
    logic          wr_en;
    logic [W-1:0]  wdata;
    logic          rd_en;
    logic [W-1:0]  rdata;
    logic          rd_valid;
    logic [BW-1:0] in_bus;
    logic [BW-1:0] out_bus;
    logic          irq;

    io_port_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .addr     (addr),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .in_bus   (in_bus),
        .out_bus  (out_bus),
        .irq      (irq)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;

    // Model: v1/v2/v3 = in_bus sampled one/two/three edges ago; n = edges since reset.
    logic [BW-1:0] v1, v2, v3;
    int            n;
    logic [C-1:0]  m_flags, m_mask;
    logic          m_irq, m_valid;
    logic [BW-1:0] m_out;
    logic [W-1:0]  m_rdata;

    task automatic model_reset();
        v1 = '0; v2 = '0; v3 = '0; n = 0;
        m_flags = '0; m_mask = '0; m_irq = 1'b0; m_valid = 1'b0;
        m_out = '0; m_rdata = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_read(input logic [3:0] a);
        logic [W-1:0] r;
        r = '0;
        if (int'(a) < C) r = v2[int'(a)*W +: W];
        else if (a == 4'h8) r[C-1:0] = m_flags;
        else if (a == 4'h9) r[C-1:0] = m_mask;
        else if (a == 4'hA) r[0] = m_irq;
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_valid));
        chk({tag, ".rdata"},    64'(rdata),    64'(m_rdata));
        chk({tag, ".out_bus"},  64'(out_bus),  64'(m_out));
        chk({tag, ".irq"},      64'(irq),      64'(m_irq));
    endtask

    task automatic tick(input string tag);
        logic [C-1:0] set, clr;
        logic         nirq;
        n++;
        set = '0;
        if (n >= 4) begin
            for (int k = 0; k < C; k++) set[k] = (v2[k*W +: W] != v3[k*W +: W]);
        end
        clr = '0;
        if (rd_en) begin
            m_rdata = m_read(addr);
            m_valid = 1'b1;
            if (addr == 4'h8) clr = m_flags;
        end else begin
            m_valid = 1'b0;
        end
`ifdef IO_PORT_IRQ_EN
        nirq = |(m_flags & m_mask);
        if (wr_en && addr == 4'h9) m_mask = wdata[C-1:0];
`else
        nirq = 1'b0;
`endif
        if (wr_en && int'(addr) < C) m_out[int'(addr)*W +: W] = wdata;
        m_flags = (m_flags & ~clr) | set;
        m_irq   = nirq;
        v3 = v2; v2 = v1; v1 = in_bus;
        @(posedge clk_in);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    logic [BW-1:0] saved;
    int            ch;

    initial begin
        reset = 1'b0; addr = '0; wr_en = 1'b0; wdata = '0; rd_en = 1'b0; in_bus = '0;
        model_reset();
        #22;
        check_all("reset");
        reset = 1'b1;

        // Single write lands in channel 1 only.
        addr = 4'h1; wdata = 8'h5A; wr_en = 1'b1;
        tick("wr_ch1");
        idle();
        chk("wr_ch1_lit", 64'(out_bus), 64'h0000_5A00);

        // Input change is visible after the synchroniser and raises a sticky flag.
        in_bus[0 +: W] = 8'h04;
        tick("w1"); tick("w2"); tick("w3");
        rd_en = 1'b1; addr = 4'h0;
        tick("rd_ch0");
        chk("rd_ch0_lit", 64'(rdata), 64'h04);
        addr = 4'h8;
        tick("rd_flags1");
        chk("flags1_lit", 64'(rdata), 64'h01);
        tick("rd_flags2");
        chk("flags2_lit", 64'(rdata), 64'h00);
        idle();
        tick("hold");
        chk("rdata_hold", 64'(rdata), 64'h00);

        // Flag set on the same edge as a clearing read survives.
        in_bus[2*W +: W] = 8'h33;
        tick("c2a"); tick("c2b");
        rd_en = 1'b1; addr = 4'h8;
        tick("rd_collide");
        chk("collide_bit2", 64'(rdata[2]), 64'h0);
        idle();
        tick("gap");
        rd_en = 1'b1; addr = 4'h8;
        tick("rd_after");
        chk("after_bit2", 64'(rdata[2]), 64'h1);
        idle();

        // Mask and interrupt.
        wr_en = 1'b1; addr = 4'h9; wdata = 8'h02;
        tick("wr_mask");
        idle();
        in_bus[1*W +: W] = ~in_bus[1*W +: W];
        for (int i = 0; i < 5; i++) tick("irq_wait");
`ifdef IO_PORT_IRQ_EN
        chk("irq_set_lit", 64'(irq), 64'h1);
`else
        chk("irq_off_lit", 64'(irq), 64'h0);
`endif
        rd_en = 1'b1; addr = 4'h8;
        tick("irq_clr_rd");
        idle();
        tick("irq_clr");
        chk("irq_clr_lit", 64'(irq), 64'h0);

        // Unmapped addresses read zero and ignore writes.
        rd_en = 1'b1; addr = 4'h6;
        tick("rd_6");
        chk("rd_6_lit", 64'(rdata), 64'h0);
        addr = 4'hC;
        tick("rd_C");
        chk("rd_C_lit", 64'(rdata), 64'h0);
        idle();
        saved = m_out;
        wr_en = 1'b1; wdata = 8'hFF; addr = 4'h6;
        tick("wr_6");
        addr = 4'hC;
        tick("wr_C");
        addr = 4'h8;
        tick("wr_flags");
        idle();
        chk("unmapped_wr_lit", 64'(out_bus), 64'(saved));

        // Simultaneous read and write on one channel.
        rd_en = 1'b1; wr_en = 1'b1; addr = 4'h0; wdata = 8'hAA;
        tick("rdwr_same");
        idle();

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch = int'($urandom_range(0, C - 1));
                in_bus[ch*W +: W] = W'($urandom);
            end
            addr  = 4'($urandom_range(0, 3) == 0 ? $urandom_range(8, 15) : $urandom_range(0, 7));
            wr_en = 1'($urandom_range(0, 2) == 0);
            rd_en = 1'($urandom_range(0, 1));
            wdata = W'($urandom);
            tick("rand");
        end
        idle();

        // Reset asserted in the middle of a read.
        rd_en = 1'b1; addr = 4'h0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("midrd_reset");
        @(posedge clk_in);
        #2;
        rd_en = 1'b0;
        check_all("in_reset");
        reset = 1'b1;
        tick("post_reset");
        chk("post_reset_valid_lit", 64'(rd_valid), 64'h0);
        tick("post_reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
